hd44780_bus_monitor: RTL and testbench
======================================

Name: hd44780_bus_monitor

Overview:
- Receiving end of the 8-bit HD44780/LCD1602 write bus that our LCD controller drives (rs, rw, enable, data).
- Samples each transaction on the falling edge of E and decodes instructions.
- Keeps a 32-byte DDRAM shadow (2x16 visible window) plus display/entry/function state.
- Used as an on-chip mirror for bring-up and as a checker for the LCD driver in simulation and on FPGA.

Parameters:
- SYNC_STAGES, 2, flops per input synchronizer (min 2).
- BUSY_CMD_CYCLES, 4, clk cycles busy after any non-clear transaction (min 1).
- NUM_COLS, 16, visible columns per line; fixed at 16 in this revision.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- lcd_rs  in  1  register select; asynchronous to clk.
- lcd_rw  in  1  1 = read cycle; asynchronous.
- lcd_e  in  1  enable strobe; asynchronous; falling edge latches a transaction.
- lcd_data  in  8  bus data; asynchronous.
- rd_idx  in  5  shadow read index (0-15 line 1, 16-31 line 2).
- rd_data  out  8  shadow[rd_idx], registered.
- char_wr_valid  out  1  1-cycle pulse when a character is stored.
- char_wr_idx  out  5  index written.
- char_wr_data  out  8  byte written.
- cmd_valid  out  1  1-cycle pulse when an instruction is decoded.
- cmd_code  out  8  raw instruction byte.
- ac  out  7  DDRAM address counter.
- disp_on, cursor_on, blink_on  out  1 each  display-control bits.
- entry_inc  out  1  I/D bit.
- func_cfg  out  3  {DL,N,F} from the last function set.
- busy  out  1  emulated busy flag.
- err_overrun  out  1  sticky: E falling edge seen while busy.
- err_read  out  1  sticky: transaction with rw=1.
- err_oob  out  1  sticky: character write dropped (outside window or CGRAM mode).

Behaviour:
- Reset (reset=0 at posedge clk):
  - FSM=CLEARING, clr_idx=0, busy=1, ac=0, entry_inc=1.
  - disp_on, cursor_on, blink_on = 0; func_cfg=0; cg_mode=0.
  - All err_* = 0; all pulses = 0; cmd_code=0; char_wr_idx=0; char_wr_data=0; rd_data=0.
  - Reset mid-operation aborts everything and restarts CLEARING.
- Input sync: rs, rw, e and data each pass through SYNC_STAGES flops. Edge detect: e_sync_d=1 and e_sync=0. rs, rw and data are captured from the synchronized copies in that same cycle. The bus is stable for many cycles around E.
- FSM:
  - CLEARING: writes 0x20 to shadow[clr_idx], one entry per cycle, for 32 cycles, then goes to IDLE with busy=0.
  - IDLE: on an edge, decode (below) and go to EXEC with cnt=BUSY_CMD_CYCLES-1, busy=1. Clear display goes to CLEARING instead.
  - EXEC: decrement cnt; at 0 go to IDLE with busy=0.
- Edge while busy (EXEC or CLEARING): the transaction is dropped, err_overrun=1, and the state is unchanged.
- Edge with rw=1: err_read=1, no state change, no busy, no pulses.
- Decode when rs=0 (cmd_valid=1, cmd_code=byte). Priority is by the highest set bit:
  - 0x80|a: ac=a[6:0], cg_mode=0.
  - 0x40: cg_mode=1.
  - 0x20: func_cfg=data[4:2].
  - 0x10: if data[3]=0, cursor move, using ac±1 by data[2] with wrap; if data[3]=1, display shift, ignored.
  - 0x08: disp_on, cursor_on, blink_on = data[2:0].
  - 0x04: entry_inc=data[1]; the S bit is ignored.
  - 0x02: ac=0.
  - 0x01: ac=0, entry_inc=1, then CLEARING.
  - 0x00: no-op.
- Decode when rs=1:
  - Index mapping: ac 0x00-0x0F maps to idx=ac[3:0]; ac 0x40-0x4F maps to idx=16+ac[3:0].
  - If cg_mode=1 or ac is outside both ranges, the write is dropped and err_oob=1.
  - Otherwise shadow[idx]=byte, with char_wr_valid/idx/data pulsed on the decode cycle.
  - ac then advances by entry_inc whether or not the write was stored.
- ac arithmetic (7-bit, HD44780 wrap):
  - Increment: 0x27 goes to 0x40, 0x67 goes to 0x00.
  - Decrement: 0x00 goes to 0x67, 0x40 goes to 0x27.
  - Values 0x28-0x3F and 0x68-0x7F are reachable only via set-DDRAM; they step ±1 with no wrap. 0x7F+1 goes to 0x00.
- Read port: rd_data is valid 1 cycle after rd_idx. On a same-cycle write to the same index, rd_data returns the old value. During CLEARING, reads return partially cleared contents.

Decomposition:
- Shared package hd44780_pkg holds the instruction opcode/mask constants and the address constants: LINE1_BASE=0x00, LINE2_BASE=0x40, LINE_END=0x27, BLANK=0x20. The existing LCD controller reuses the same package.
- One sub-module: bit_synchronizer (parameterised width and SYNC_STAGES), instantiated for rs, rw, e and data.

Test Plan:
- Reset released -> busy=1 for exactly 32 cycles; all 32 rd_data = 0x20; ac=0; entry_inc=1.
- Writes 0x38, 0x06, 0x0C, 0x01 spaced 100 cycles apart, then rs=1 with 'A' (0x41) -> func_cfg=3'b110, disp_on=1, cursor_on=0, shadow[0]=0x41, ac=0x01.
- Instruction 0xC0, then data 'Z' -> char_wr_idx=16, shadow[16]=0x5A, ac=0x41.
- Instruction 0x8F, then two data writes 'x', 'y' -> shadow[15]='x'; the second write is dropped, err_oob=1, ac=0x11.
- Instruction 0x04 (decrement) at ac=0x40 and a data write -> shadow[16] written, ac=0x27. A further write is dropped (oob) and ac becomes 0x26.
- Two E falling edges 2 cycles apart (BUSY_CMD_CYCLES=4) -> second dropped, err_overrun=1. A separate rw=1 edge -> err_read=1 and ac unchanged. Reset low mid-CLEARING -> clr_idx restarts at 0.

Source files
------------

// File: rtl/hd44780_pkg.sv
// Shared HD44780 instruction and DDRAM address constants, used by the LCD driver and the bus monitor.
package hd44780_pkg;
   localparam logic [7:0] CMD_SET_DDRAM  = 8'h80;
   localparam logic [7:0] CMD_SET_CGRAM  = 8'h40;
   localparam logic [7:0] CMD_FUNC_SET   = 8'h20;
   localparam logic [7:0] CMD_SHIFT      = 8'h10;
   localparam logic [7:0] CMD_DISP_CTRL  = 8'h08;
   localparam logic [7:0] CMD_ENTRY_MODE = 8'h04;
   localparam logic [7:0] CMD_HOME       = 8'h02;
   localparam logic [7:0] CMD_CLEAR      = 8'h01;

   localparam logic [6:0] LINE1_BASE = 7'h00;
   localparam logic [6:0] LINE2_BASE = 7'h40;
   localparam logic [6:0] LINE_END   = 7'h27;
   localparam logic [7:0] BLANK      = 8'h20;

   typedef enum logic [1:0] {
      ST_CLEARING,
      ST_IDLE,
      ST_EXEC
   } mon_state_t;

   // Address counter step with the two-line wrap (0x27<->0x40, 0x67<->0x00).
   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
      logic [6:0] res;
      if (inc) begin
         if (ac == LINE_END)                   res = LINE2_BASE;
         else if (ac == LINE2_BASE + LINE_END) res = LINE1_BASE;
         else                                  res = ac + 7'd1;
      end else begin
         if (ac == LINE1_BASE)                 res = LINE2_BASE + LINE_END;
         else if (ac == LINE2_BASE)            res = LINE_END;
         else                                  res = ac - 7'd1;
      end
      return res;
   endfunction
endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for asynchronous LCD bus inputs.
module bit_synchronizer #(
   parameter int WIDTH       = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   logic [WIDTH-1:0] stages [SYNC_STAGES];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) stages[i] <= '0;
      end else begin
         stages[0] <= din;
         for (int i = 1; i < SYNC_STAGES; i++) stages[i] <= stages[i-1];
      end
   end

   assign dout = stages[SYNC_STAGES-1];
endmodule

// File: rtl/hd44780_bus_monitor.sv
// HD44780 write-bus monitor: samples on E falling edge, decodes instructions, keeps a 2x16 DDRAM shadow.
//  state       | meaning
//  ST_CLEARING | filling shadow with blanks, one entry per cycle; busy
//  ST_IDLE     | waiting for an E falling edge
//  ST_EXEC     | emulated instruction execution time; busy
module hd44780_bus_monitor
   import hd44780_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int BUSY_CMD_CYCLES = 4,
   parameter int NUM_COLS        = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic       lcd_e,
   input  logic [7:0] lcd_data,
   input  logic [4:0] rd_idx,
   output logic [7:0] rd_data,
   output logic       char_wr_valid,
   output logic [4:0] char_wr_idx,
   output logic [7:0] char_wr_data,
   output logic       cmd_valid,
   output logic [7:0] cmd_code,
   output logic [6:0] ac,
   output logic       disp_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       entry_inc,
   output logic [2:0] func_cfg,
   output logic       busy,
   output logic       err_overrun,
   output logic       err_read,
   output logic       err_oob
);
   localparam int         CNT_W    = (BUSY_CMD_CYCLES > 1) ? $clog2(BUSY_CMD_CYCLES) : 1;
   localparam logic [6:0] COL_LAST = 7'(NUM_COLS - 1);

   logic       rs_s, rw_s, e_s, e_d;
   logic [7:0] data_s;
   logic       e_fall;

   bit_synchronizer #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES)) u_sync_rs
      (.clk(clk), .reset(reset), .din(lcd_rs), .dout(rs_s));
   bit_synchronizer #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES)) u_sync_rw
      (.clk(clk), .reset(reset), .din(lcd_rw), .dout(rw_s));
   bit_synchronizer #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES)) u_sync_e
      (.clk(clk), .reset(reset), .din(lcd_e), .dout(e_s));
   bit_synchronizer #(.WIDTH(8), .SYNC_STAGES(SYNC_STAGES)) u_sync_data
      (.clk(clk), .reset(reset), .din(lcd_data), .dout(data_s));

   assign e_fall = e_d & ~e_s;

   mon_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [4:0]       clr_idx, clr_idx_nxt;
   logic [6:0]       ac_nxt;
   logic             disp_nxt, cursor_nxt, blink_nxt, inc_nxt, cg_mode, cg_nxt;
   logic [2:0]       func_nxt;
   logic             ovr_nxt, rd_err_nxt, oob_nxt;
   logic             cmd_valid_nxt, char_valid_nxt;
   logic [7:0]       cmd_code_nxt, char_data_nxt;
   logic [4:0]       char_idx_nxt;
   logic             mem_we;
   logic [4:0]       mem_waddr;
   logic [7:0]       mem_wdata;
   logic             in_line1, in_line2;
   logic [7:0]       shadow [32];

   assign in_line1 = (ac <= COL_LAST);
   assign in_line2 = (ac >= LINE2_BASE) && (ac <= LINE2_BASE + COL_LAST);
   assign busy     = (state != ST_IDLE);

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      clr_idx_nxt    = clr_idx;
      ac_nxt         = ac;
      disp_nxt       = disp_on;
      cursor_nxt     = cursor_on;
      blink_nxt      = blink_on;
      inc_nxt        = entry_inc;
      func_nxt       = func_cfg;
      cg_nxt         = cg_mode;
      ovr_nxt        = err_overrun;
      rd_err_nxt     = err_read;
      oob_nxt        = err_oob;
      cmd_valid_nxt  = 1'b0;
      char_valid_nxt = 1'b0;
      cmd_code_nxt   = cmd_code;
      char_idx_nxt   = char_wr_idx;
      char_data_nxt  = char_wr_data;
      mem_we         = 1'b0;
      mem_waddr      = clr_idx;
      mem_wdata      = BLANK;

      case (state)
         ST_CLEARING: begin
            mem_we = 1'b1;
            if (e_fall) ovr_nxt = 1'b1;
            if (clr_idx == 5'd31) begin
               state_nxt   = ST_IDLE;
               clr_idx_nxt = 5'd0;
            end else begin
               clr_idx_nxt = clr_idx + 5'd1;
            end
         end
         ST_EXEC: begin
            if (e_fall) ovr_nxt = 1'b1;
            if (cnt == '0) state_nxt = ST_IDLE;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         default: begin
            if (e_fall) begin
               if (rw_s) begin
                  rd_err_nxt = 1'b1;
               end else begin
                  state_nxt = ST_EXEC;
                  cnt_nxt   = CNT_W'(BUSY_CMD_CYCLES - 1);
                  if (!rs_s) begin
                     cmd_valid_nxt = 1'b1;
                     cmd_code_nxt  = data_s;
                     if (data_s[7]) begin
                        ac_nxt = data_s[6:0];
                        cg_nxt = 1'b0;
                     end else if (data_s[6]) begin
                        cg_nxt = 1'b1;
                     end else if (data_s[5]) begin
                        func_nxt = data_s[4:2];
                     end else if (data_s[4]) begin
                        if (!data_s[3]) ac_nxt = ac_step(ac, data_s[2]);
                     end else if (data_s[3]) begin
                        {disp_nxt, cursor_nxt, blink_nxt} = data_s[2:0];
                     end else if (data_s[2]) begin
                        inc_nxt = data_s[1];
                     end else if (data_s[1]) begin
                        ac_nxt = LINE1_BASE;
                     end else if (data_s[0]) begin
                        ac_nxt      = LINE1_BASE;
                        inc_nxt     = 1'b1;
                        state_nxt   = ST_CLEARING;
                        clr_idx_nxt = 5'd0;
                     end
                  end else begin
                     // ac advances even when the character is dropped
                     ac_nxt = ac_step(ac, entry_inc);
                     if (!cg_mode && (in_line1 || in_line2)) begin
                        mem_we         = 1'b1;
                        mem_waddr      = {in_line2, ac[3:0]};
                        mem_wdata      = data_s;
                        char_valid_nxt = 1'b1;
                        char_idx_nxt   = {in_line2, ac[3:0]};
                        char_data_nxt  = data_s;
                     end else begin
                        oob_nxt = 1'b1;
                     end
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= ST_CLEARING;
         cnt           <= '0;
         clr_idx       <= 5'd0;
         e_d           <= 1'b0;
         ac            <= 7'd0;
         disp_on       <= 1'b0;
         cursor_on     <= 1'b0;
         blink_on      <= 1'b0;
         entry_inc     <= 1'b1;
         func_cfg      <= 3'd0;
         cg_mode       <= 1'b0;
         err_overrun   <= 1'b0;
         err_read      <= 1'b0;
         err_oob       <= 1'b0;
         cmd_valid     <= 1'b0;
         char_wr_valid <= 1'b0;
         cmd_code      <= 8'd0;
         char_wr_idx   <= 5'd0;
         char_wr_data  <= 8'd0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         clr_idx       <= clr_idx_nxt;
         e_d           <= e_s;
         ac            <= ac_nxt;
         disp_on       <= disp_nxt;
         cursor_on     <= cursor_nxt;
         blink_on      <= blink_nxt;
         entry_inc     <= inc_nxt;
         func_cfg      <= func_nxt;
         cg_mode       <= cg_nxt;
         err_overrun   <= ovr_nxt;
         err_read      <= rd_err_nxt;
         err_oob       <= oob_nxt;
         cmd_valid     <= cmd_valid_nxt;
         char_wr_valid <= char_valid_nxt;
         cmd_code      <= cmd_code_nxt;
         char_wr_idx   <= char_idx_nxt;
         char_wr_data  <= char_data_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) shadow[mem_waddr] <= mem_wdata;
   end

   // Read-before-write: a same-cycle write to rd_idx shows up one cycle later.
   always_ff @(posedge clk) begin
      if (!reset) rd_data <= 8'd0;
      else        rd_data <= shadow[rd_idx];
   end
endmodule

// File: tb/tb_hd44780_bus_monitor.sv
// Self-checking bench for hd44780_bus_monitor: directed scenarios plus random bus traffic vs a behavioural model.
module tb_hd44780_bus_monitor;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
   logic [7:0] lcd_data = 8'd0;
   logic [4:0] rd_idx = 5'd0;
   logic [7:0] rd_data;
   logic       char_wr_valid, cmd_valid;
   logic [4:0] char_wr_idx;
   logic [7:0] char_wr_data, cmd_code;
   logic [6:0] ac;
   logic       disp_on, cursor_on, blink_on, entry_inc;
   logic [2:0] func_cfg;
   logic       busy, err_overrun, err_read, err_oob;

   hd44780_bus_monitor #(.SYNC_STAGES(2), .BUSY_CMD_CYCLES(4), .NUM_COLS(16)) dut (
      .clk(clk), .reset(reset), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
      .lcd_data(lcd_data), .rd_idx(rd_idx), .rd_data(rd_data),
      .char_wr_valid(char_wr_valid), .char_wr_idx(char_wr_idx), .char_wr_data(char_wr_data),
      .cmd_valid(cmd_valid), .cmd_code(cmd_code), .ac(ac), .disp_on(disp_on),
      .cursor_on(cursor_on), .blink_on(blink_on), .entry_inc(entry_inc), .func_cfg(func_cfg),
      .busy(busy), .err_overrun(err_overrun), .err_read(err_read), .err_oob(err_oob));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // pulse counters observed on the DUT outputs
   int d_chars = 0;
   int d_cmds  = 0;
   always @(negedge clk) begin
      if (char_wr_valid) d_chars++;
      if (cmd_valid)     d_cmds++;
   end

   // behavioural reference model
   logic [7:0] m_shadow [32];
   int         m_ac;
   logic       m_inc, m_disp, m_cur, m_blink, m_cg, m_eo, m_er, m_eb;
   logic [2:0] m_func;
   logic [7:0] m_code, m_cdata;
   logic [4:0] m_cidx;
   int         m_chars = 0;
   int         m_cmds  = 0;

   function automatic int m_next_ac(input int a, input logic inc);
      if (inc) begin
         if (a == 'h27) return 'h40;
         if (a == 'h67) return 0;
         return (a + 1) % 128;
      end
      if (a == 0)    return 'h67;
      if (a == 'h40) return 'h27;
      return a - 1;
   endfunction

   task automatic m_init();
      for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
      m_ac = 0; m_inc = 1; m_disp = 0; m_cur = 0; m_blink = 0; m_cg = 0;
      m_eo = 0; m_er = 0; m_eb = 0; m_func = 3'd0;
      m_code = 8'd0; m_cdata = 8'd0; m_cidx = 5'd0;
   endtask

   task automatic m_apply(input logic r_s, input logic r_w, input logic [7:0] d);
      int top;
      int idx;
      if (r_w) begin
         m_er = 1;
         return;
      end
      if (!r_s) begin
         m_cmds++;
         m_code = d;
         top = -1;
         for (int b = 7; b >= 0; b--) if (d[b] && top < 0) top = b;
         case (top)
            7: begin m_ac = int'(d) - 128; m_cg = 0; end
            6: m_cg = 1;
            5: m_func = d[4:2];
            4: if (!d[3]) m_ac = m_next_ac(m_ac, d[2]);
            3: begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
            2: m_inc = d[1];
            1: m_ac = 0;
            0: begin
               m_ac = 0; m_inc = 1;
               for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
            end
            default: ;
         endcase
      end else begin
         idx = -1;
         if (!m_cg && m_ac < 16) idx = m_ac;
         if (!m_cg && m_ac >= 64 && m_ac < 80) idx = m_ac - 48;
         if (idx >= 0) begin
            m_shadow[idx] = d;
            m_chars++;
            m_cidx = 5'(idx);
            m_cdata = d;
         end else begin
            m_eb = 1;
         end
         m_ac = m_next_ac(m_ac, m_inc);
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic r_s, input logic r_w, input logic [7:0] d);
      @(negedge clk);
      lcd_rs = r_s; lcd_rw = r_w; lcd_data = d;
      repeat (3) @(negedge clk);
      lcd_e = 1'b1;
      repeat (4) @(negedge clk);
      lcd_e = 1'b0;
      repeat (45) @(negedge clk);
      m_apply(r_s, r_w, d);
   endtask

   task automatic read_chk(input string tag, input int idx, input logic [7:0] exp);
      @(negedge clk);
      rd_idx = 5'(idx);
      @(negedge clk);
      check(tag, {24'd0, rd_data}, {24'd0, exp});
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < 32; i++) read_chk(tag, i, m_shadow[i]);
   endtask

   task automatic compare_all(input string tag);
      check({tag, ":ac"},        {25'd0, ac},        32'(m_ac));
      check({tag, ":entry_inc"}, {31'd0, entry_inc}, {31'd0, m_inc});
      check({tag, ":disp"},      {29'd0, disp_on, cursor_on, blink_on}, {29'd0, m_disp, m_cur, m_blink});
      check({tag, ":func_cfg"},  {29'd0, func_cfg},  {29'd0, m_func});
      check({tag, ":busy"},      {31'd0, busy},      32'd0);
      check({tag, ":errs"},      {29'd0, err_overrun, err_read, err_oob}, {29'd0, m_eo, m_er, m_eb});
      check({tag, ":cmd_code"},  {24'd0, cmd_code},  {24'd0, m_code});
      check({tag, ":char_idx"},  {27'd0, char_wr_idx},  {27'd0, m_cidx});
      check({tag, ":char_data"}, {24'd0, char_wr_data}, {24'd0, m_cdata});
      check({tag, ":n_chars"},   32'(d_chars), 32'(m_chars));
      check({tag, ":n_cmds"},    32'(d_cmds),  32'(m_cmds));
   endtask

   task automatic busy_len(input string tag);
      int cycles;
      cycles = 0;
      while (busy && cycles < 100) begin
         @(negedge clk);
         cycles++;
      end
      check(tag, 32'(cycles), 32'd32);
   endtask

   initial begin
      int         top;
      logic       r_s, r_w;
      logic [7:0] d;

      m_init();
      repeat (3) @(negedge clk);
      check("rst:busy",      {31'd0, busy},      32'd1);
      check("rst:ac",        {25'd0, ac},        32'd0);
      check("rst:entry_inc", {31'd0, entry_inc}, 32'd1);
      check("rst:flags",     {24'd0, disp_on, cursor_on, blink_on, func_cfg, char_wr_valid, cmd_valid},
            32'd0);
      check("rst:errs",      {29'd0, err_overrun, err_read, err_oob}, 32'd0);
      check("rst:regs",      {cmd_code, char_wr_data, rd_data, 3'd0, char_wr_idx}, 32'd0);

      reset = 1'b1;
      busy_len("init:busy_cycles");
      read_all("init:shadow");
      compare_all("init");

      xfer(0, 0, 8'h38);
      xfer(0, 0, 8'h06);
      xfer(0, 0, 8'h0C);
      xfer(0, 0, 8'h01);
      xfer(1, 0, 8'h41);
      check("seq1:func_cfg",  {29'd0, func_cfg},  32'b110);
      check("seq1:disp_on",   {31'd0, disp_on},   32'd1);
      check("seq1:cursor_on", {31'd0, cursor_on}, 32'd0);
      check("seq1:ac",        {25'd0, ac},        32'h01);
      read_chk("seq1:shadow0", 0, 8'h41);
      compare_all("seq1");

      xfer(0, 0, 8'hC0);
      xfer(1, 0, 8'h5A);
      check("line2:char_idx", {27'd0, char_wr_idx}, 32'd16);
      check("line2:ac",       {25'd0, ac},          32'h41);
      read_chk("line2:shadow16", 16, 8'h5A);

      xfer(0, 0, 8'h8F);
      xfer(1, 0, 8'h78);
      xfer(1, 0, 8'h79);
      read_chk("edge:shadow15", 15, 8'h78);
      check("edge:err_oob", {31'd0, err_oob}, 32'd1);
      check("edge:ac",      {25'd0, ac},      32'h11);
      compare_all("edge");

      xfer(0, 0, 8'hC0);
      xfer(0, 0, 8'h04);
      xfer(1, 0, 8'h71);
      read_chk("dec:shadow16", 16, 8'h71);
      check("dec:ac_wrap", {25'd0, ac}, 32'h27);
      xfer(1, 0, 8'h72);
      check("dec:ac_oob", {25'd0, ac}, 32'h26);
      compare_all("dec");

      xfer(0, 0, 8'h06);
      xfer(0, 0, 8'h80);
      // two E falling edges two cycles apart: the second lands during EXEC
      @(negedge clk);
      lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h51;
      repeat (3) @(negedge clk);
      lcd_e = 1'b1;
      @(negedge clk) lcd_e = 1'b0;
      @(negedge clk) lcd_e = 1'b1;
      @(negedge clk) lcd_e = 1'b0;
      repeat (45) @(negedge clk);
      m_apply(1, 0, 8'h51);
      m_eo = 1;
      check("ovr:err_overrun", {31'd0, err_overrun}, 32'd1);
      check("ovr:ac",          {25'd0, ac},          32'h01);
      read_chk("ovr:shadow0", 0, 8'h51);

      xfer(0, 1, 8'h80);
      check("rd:err_read", {31'd0, err_read}, 32'd1);
      check("rd:ac",       {25'd0, ac},       32'h01);
      compare_all("rd");

      // reset in the middle of a clear restarts the full 32-entry fill
      @(negedge clk);
      lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h01;
      repeat (3) @(negedge clk);
      lcd_e = 1'b1;
      repeat (4) @(negedge clk);
      lcd_e = 1'b0;
      repeat (12) @(negedge clk);
      check("midclr:busy", {31'd0, busy}, 32'd1);
      m_apply(0, 0, 8'h01);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      m_init();
      reset = 1'b1;
      busy_len("midclr:busy_cycles");
      read_all("midclr:shadow");
      compare_all("midclr");

      for (int it = 0; it < 240; it++) begin
         r_w = ($urandom_range(0, 99) < 4);
         r_s = 1'($urandom_range(0, 1));
         if (r_s || r_w) begin
            d = 8'($urandom);
         end else begin
            top = $urandom_range(0, 9);
            if (top >= 8) begin
               top = $urandom_range(0, 2);
               d = (top == 0) ? 8'h80 | 8'($urandom_range(0, 15))
                 : (top == 1) ? 8'hC0 | 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
               d[7] = 1'b1;
            end else if (top == 0 && $urandom_range(0, 3) != 0) begin
               d = 8'h00;
            end else begin
               d = 8'((1 << top) | ($urandom & ((1 << top) - 1)));
            end
         end
         xfer(r_s, r_w, d);
         if (it % 12 == 11) compare_all("rand");
      end
      compare_all("rand_end");
      read_all("rand_end:shadow");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
